buffer_read_ctrl: RTL and testbench

BUFFER_READ_CTRL -- requirements
Module: buffer_read_ctrl

---
 rtl/buffer_pkg.sv | 21 ++
 rtl/buffer_lane_addr.sv | 17 +
 rtl/buffer_read_ctrl.sv | 153 +++++++++++++++
 tb/tb_buffer_read_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/buffer_pkg.sv
// Shared parameters and FSM encoding for the buffer read controller.
package buffer_pkg;

    localparam int ROW_SIZE_DEF  = 8;
    localparam int COLUMNS_DEF   = 32;
    localparam int PAR_WRITE_DEF = 4;
    localparam int PAR_READ_DEF  = 4;

    function automatic int addr_w(input int columns);
        return (columns > 1) ? $clog2(columns) : 1;
    endfunction

    localparam int ADDR_W_DEF = addr_w(COLUMNS_DEF);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

endpackage

// File: rtl/buffer_lane_addr.sv
// Per-lane wrapped read addresses; COLUMNS is a power of two,
// so the natural ADDR_W-bit wrap gives the modulo.
module buffer_lane_addr
    import buffer_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int PAR_READ = PAR_READ_DEF
) (
    input  logic [ADDR_W-1:0]          rd_ptr,
    output logic [PAR_READ*ADDR_W-1:0] raddr
);

    for (genvar i = 0; i < PAR_READ; i++) begin : g_lane
        assign raddr[i*ADDR_W +: ADDR_W] = rd_ptr + ADDR_W'(i);
    end

endmodule

// File: rtl/buffer_read_ctrl.sv
// Frame-based multi-lane reader of a circular row buffer with
// occupancy tracking and a registered beat output.
module buffer_read_ctrl
    import buffer_pkg::*;
#(
    parameter int  ROW_SIZE  = ROW_SIZE_DEF,
    parameter int  COLUMNS   = COLUMNS_DEF,
    parameter int  PAR_WRITE = PAR_WRITE_DEF,
    parameter int  PAR_READ  = PAR_READ_DEF,
    localparam int ADDR_W    = addr_w(COLUMNS),
    localparam int PW_W      = $clog2(PAR_WRITE + 1),
    localparam int PR_W      = $clog2(PAR_READ + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [PW_W-1:0]              push_n,
    output logic [ADDR_W:0]              free_cnt,
    input  logic                         start,
    input  logic [ADDR_W:0]              len,
    output logic [PAR_READ*ADDR_W-1:0]   raddr,
    input  logic [ROW_SIZE*PAR_READ-1:0] rdata,
    output logic [ROW_SIZE*PAR_READ-1:0] out_data,
    output logic [PR_W-1:0]              out_lanes,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_last,
    output logic                         busy,
    output logic                         done,
    output logic                         ovf
);

    localparam int CW = ADDR_W + 1;
    localparam int SW = ADDR_W + 2;
    localparam logic [CW-1:0] COLS   = CW'(COLUMNS);
    localparam logic [CW-1:0] PR_CNT = CW'(PAR_READ);

    state_e                       state_q, state_d;
    logic [ADDR_W-1:0]            rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]                occ_q, occ_d;
    logic [CW-1:0]                rem_q, rem_d;
    logic [ROW_SIZE*PAR_READ-1:0] out_data_q, out_data_d;
    logic [PR_W-1:0]              out_lanes_q, out_lanes_d;
    logic                         out_valid_q, out_valid_d;
    logic                         out_last_q, out_last_d;
    logic                         done_q, done_d;
    logic                         ovf_q, ovf_d;

    logic [PR_W-1:0] n;
    logic            issue;
    logic [CW-1:0]   popped;
    logic [SW-1:0]   occ_sum;

    buffer_lane_addr #(
        .ADDR_W   (ADDR_W),
        .PAR_READ (PAR_READ)
    ) u_lane_addr (
        .rd_ptr (rd_ptr_q),
        .raddr  (raddr)
    );

    // A beat needs all n rows present and a free or draining output slot.
    always_comb begin
        n      = (rem_q >= PR_CNT) ? PR_W'(PAR_READ) : PR_W'(rem_q);
        issue  = (state_q == ST_RUN) && (occ_q >= CW'(n))
                 && (!out_valid_q || out_ready);
        popped = issue ? CW'(n) : '0;
    end

    // Pushes past the free space saturate and latch the error flag.
    always_comb begin
        occ_sum = SW'(occ_q) + SW'(push_n) - SW'(popped);
        ovf_d   = ovf_q || (CW'(push_n) > free_cnt);
        occ_d   = (occ_sum > SW'(COLS)) ? COLS : occ_sum[CW-1:0];
    end

    always_comb begin
        state_d     = state_q;
        rd_ptr_d    = rd_ptr_q;
        rem_d       = rem_q;
        out_data_d  = out_data_q;
        out_lanes_d = out_lanes_q;
        out_valid_d = out_valid_q && !out_ready;
        out_last_d  = out_last_q;
        done_d      = 1'b0;
        if (issue) begin
            for (int i = 0; i < PAR_READ; i++) begin
                out_data_d[i*ROW_SIZE +: ROW_SIZE] =
                    (i < int'(n)) ? rdata[i*ROW_SIZE +: ROW_SIZE] : '0;
            end
            out_lanes_d = n;
            out_valid_d = 1'b1;
            out_last_d  = (rem_q == CW'(n));
            rd_ptr_d    = rd_ptr_q + ADDR_W'(n);
            rem_d       = rem_q - CW'(n);
        end
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    rem_d   = len;
                    state_d = (len == '0) ? ST_FLUSH : ST_RUN;
                end
            end
            ST_RUN: begin
                if (issue && (rem_q == CW'(n))) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (!out_valid_q || out_ready) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            rd_ptr_q    <= '0;
            occ_q       <= '0;
            rem_q       <= '0;
            out_data_q  <= '0;
            out_lanes_q <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_ptr_q    <= rd_ptr_d;
            occ_q       <= occ_d;
            rem_q       <= rem_d;
            out_data_q  <= out_data_d;
            out_lanes_q <= out_lanes_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            done_q      <= done_d;
            ovf_q       <= ovf_d;
        end
    end

    assign free_cnt  = COLS - occ_q;
    assign out_data  = out_data_q;
    assign out_lanes = out_lanes_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_buffer_read_ctrl.sv
// Directed bench for buffer_read_ctrl: frame table plus stall,
// reset and overflow sequences against a behavioural row model.
module tb_buffer_read_ctrl;

    localparam int AW   = 5;
    localparam int RS   = 8;
    localparam int PR   = 4;
    localparam int COLS = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [2:0]    push_n;
    logic [AW:0]   free_cnt;
    logic          start;
    logic [AW:0]   len;
    logic [PR*AW-1:0] raddr;
    logic [RS*PR-1:0] rdata;
    logic [RS*PR-1:0] out_data;
    logic [2:0]    out_lanes;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic          busy;
    logic          done;
    logic          ovf;

    int checks = 0;
    int errors = 0;
    int ptr_m  = 0;

    typedef struct {
        int    push;
        int    len;
        int    nb;
        string nm;
    } vec_t;

    vec_t tbl[7];

    always #5 clk = ~clk;

    buffer_read_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .push_n    (push_n),
        .free_cnt  (free_cnt),
        .start     (start),
        .len       (len),
        .raddr     (raddr),
        .rdata     (rdata),
        .out_data  (out_data),
        .out_lanes (out_lanes),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done),
        .ovf       (ovf)
    );

    function automatic logic [7:0] row_f(input int a);
        return 8'(a * 37 + 5);
    endfunction

    always_comb begin
        rdata = '0;
        for (int i = 0; i < PR; i++) begin
            rdata[i*RS +: RS] = row_f(int'(raddr[i*AW +: AW]));
        end
    end

    function automatic logic [PR*AW-1:0] exp_raddr(input int p);
        logic [PR*AW-1:0] r;
        r = '0;
        for (int i = 0; i < PR; i++) r[i*AW +: AW] = AW'((p + i) % COLS);
        return r;
    endfunction

    function automatic logic [RS*PR-1:0] exp_beat(input int p, input int n);
        logic [RS*PR-1:0] d;
        d = '0;
        for (int i = 0; i < n; i++) d[i*RS +: RS] = row_f((p + i) % COLS);
        return d;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        push_n = '0;
        start = 1'b0;
        len = '0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        ptr_m = 0;
    endtask

    task automatic push_rows(input int k);
        while (k > 0) begin
            push_n = 3'((k > 4) ? 4 : k);
            @(negedge clk);
            k -= (k > 4) ? 4 : k;
        end
        push_n = '0;
    endtask

    task automatic run_frame(input int len_i, input int nb,
                             input int exp_free, input string nm);
        int rem = len_i;
        int beats = 0;
        int done_cyc = -1;
        chk({nm, " raddr idle"}, raddr, exp_raddr(ptr_m));
        start = 1'b1;
        len = 6'(len_i);
        @(negedge clk);
        start = 1'b0;
        len = '0;
        for (int c = 1; c <= 40 && done_cyc < 0; c++) begin
            @(negedge clk);
            if (out_valid) begin
                int n;
                n = (rem < PR) ? rem : PR;
                beats++;
                chk({nm, " beat cycle"}, c, beats);
                chk({nm, " lanes"}, out_lanes, n);
                chk({nm, " data"}, out_data, exp_beat(ptr_m, n));
                chk({nm, " last"}, out_last, rem == n);
                ptr_m = (ptr_m + n) % COLS;
                rem -= n;
            end
            if (done) begin
                done_cyc = c;
                chk({nm, " busy at done"}, busy, 0);
            end
        end
        chk({nm, " beats"}, beats, nb);
        chk({nm, " done cycle"}, done_cyc, nb + 1);
        @(negedge clk);
        chk({nm, " done pulse"}, done, 0);
        chk({nm, " free after"}, free_cnt, exp_free);
    endtask

    initial begin
        tbl[0] = '{8, 8, 2, "len8"};
        tbl[1] = '{6, 6, 2, "len6"};
        tbl[2] = '{5, 5, 2, "len5"};
        tbl[3] = '{0, 0, 0, "len0"};
        tbl[4] = '{11, 11, 3, "len11"};
        tbl[5] = '{4, 4, 1, "wrap"};
        tbl[6] = '{32, 32, 8, "full"};

        @(negedge clk);
        do_reset();
        chk("rst free", free_cnt, COLS);
        chk("rst valid", out_valid, 0);
        chk("rst lanes", out_lanes, 0);
        chk("rst data", out_data, 0);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst ovf", ovf, 0);
        chk("rst raddr", raddr, exp_raddr(0));
        rst = 1'b1;

        for (int t = 0; t < 7; t++) begin
            push_rows(tbl[t].push);
            chk({tbl[t].nm, " free pushed"}, free_cnt, COLS - tbl[t].push);
            run_frame(tbl[t].len, tbl[t].nb, COLS, tbl[t].nm);
        end

        // Backpressure: first beat held for three cycles, then full rate.
        push_rows(12);
        out_ready = 1'b0;
        start = 1'b1;
        len = 6'd12;
        @(negedge clk);
        start = 1'b0;
        len = '0;
        @(negedge clk);
        chk("stall first valid", out_valid, 1);
        chk("stall first data", out_data, exp_beat(ptr_m, 4));
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stall valid", out_valid, 1);
            chk("stall data", out_data, exp_beat(ptr_m, 4));
            chk("stall raddr", raddr, exp_raddr(ptr_m + 4));
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("resume b2 valid", out_valid, 1);
        chk("resume b2 data", out_data, exp_beat(ptr_m + 4, 4));
        chk("resume b2 last", out_last, 0);
        @(negedge clk);
        chk("resume b3 data", out_data, exp_beat(ptr_m + 8, 4));
        chk("resume b3 last", out_last, 1);
        @(negedge clk);
        chk("resume done", done, 1);
        chk("resume free", free_cnt, COLS);
        ptr_m = (ptr_m + 12) % COLS;

        // Reset in the middle of a frame.
        push_rows(12);
        start = 1'b1;
        len = 6'd12;
        @(negedge clk);
        start = 1'b0;
        len = '0;
        @(negedge clk);
        chk("midrst beat1", out_valid, 1);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst valid", out_valid, 0);
        chk("midrst data", out_data, 0);
        chk("midrst lanes", out_lanes, 0);
        chk("midrst last", out_last, 0);
        chk("midrst busy", busy, 0);
        chk("midrst free", free_cnt, COLS);
        chk("midrst raddr", raddr, exp_raddr(0));
        rst = 1'b1;
        ptr_m = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("midrst no done", done, 0);
        end
        push_rows(4);
        run_frame(4, 1, COLS, "post rst");

        // Overflow and an empty frame on a full buffer.
        push_rows(31);
        chk("ovf pre free", free_cnt, 1);
        chk("ovf pre flag", ovf, 0);
        push_rows(4);
        chk("ovf flag", ovf, 1);
        chk("ovf free sat", free_cnt, 0);
        run_frame(0, 0, 0, "len0 full");
        chk("ovf sticky", ovf, 1);
        do_reset();
        chk("ovf cleared", ovf, 0);
        chk("ovf free rst", free_cnt, COLS);
        rst = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
